// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared definitions for the MEM pipeline stage.
//   - access size encodings (SZ_*)
//   - FSM state encoding (ST_IDLE / ST_ACCESS)
//   - MEM/WB bundle widths and packed bundle type
//   - misalignment helper, used when STAGE_MEM_ALIGN_TRAP_EN is defined
package stage_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 behaves as word

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int MEMWB_DATA_W = 32;
    localparam int MEMWB_RW_W   = 5;

    typedef struct packed {
        logic [MEMWB_DATA_W-1:0] ans;
        logic [MEMWB_DATA_W-1:0] mdata;
        logic [MEMWB_RW_W-1:0]   rw;
        logic                    wreg;
        logic                    m2reg;
        logic                    buserr;
    } memwb_t;

    localparam int MEMWB_W = $bits(memwb_t);

    // Half needs a[0]=0, word (and the 2'b11 alias) needs a=00.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] a);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stage_mem_lane.sv
// stage_mem_lane: combinational byte-lane steering for the MEM stage.
// Ports:
//   size, addr_lo  access size and address bits [1:0]
//   sext           sign-extend sub-word loads
//   st_data        store data from EX/MEM register
//   rdata          read word from the data bus
//   be, wdata      little-endian byte enables / replicated store data
//   ld_data        aligned, extended load result
// Low address bits below the access size are ignored (half uses a[1],
// word uses lane 0), so a misaligned access degrades to the aligned one.
module stage_mem_lane
    import stage_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{sext & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM register, runs loads/stores over a req/ack data bus,
// stalls upstream while an access is outstanding, and drives the MEM/WB
// register. An access that sees no ack for TIMEOUT_CYC cycles is aborted
// with a one-cycle buserr_mem pulse.
// Ports:
//   clock, reset_0          clock / async active-low reset
//   *_ex                    EX bundle (valid, ans, b, rw, wreg, m2reg,
//                           wmem, size, sext)
//   stall_mem               freeze upstream stages (combinational)
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata   data-memory bus
//   ans_mem, mdata_mem, rw_mem, wreg_mem, m2reg_mem, buserr_mem  MEM/WB
// Option STAGE_MEM_ALIGN_TRAP_EN: misaligned memory ops skip the bus,
// pulse misalign_mem with their bundle and never write the register file.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] BUSERR_DATA = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        valid_ex,
    input  logic [31:0] ans_ex,
    input  logic [31:0] b_ex,
    input  logic [4:0]  rw_ex,
    input  logic        wreg_ex,
    input  logic        m2reg_ex,
    input  logic        wmem_ex,
    input  logic [1:0]  size_ex,
    input  logic        sext_ex,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ans_mem,
    output logic [31:0] mdata_mem,
    output logic [4:0]  rw_mem,
    output logic        wreg_mem,
    output logic        m2reg_mem,
`ifdef STAGE_MEM_ALIGN_TRAP_EN
    output logic        misalign_mem,
`endif
    output logic        buserr_mem
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    // EX/MEM register
    logic        em_valid, em_wreg, em_m2reg, em_wmem, em_sext;
    logic [31:0] em_ans, em_b;
    logic [4:0]  em_rw;
    logic [1:0]  em_size;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        stall, timeout, ex_mem_op, in_access, load_done;
    logic        em_mis, ex_mis;
    memwb_t      wb_q, wb_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ld;

`ifdef STAGE_MEM_ALIGN_TRAP_EN
    logic        mis_q;
    assign em_mis = is_misaligned(em_size, em_ans[1:0]) & (em_m2reg | em_wmem);
    assign ex_mis = is_misaligned(size_ex, ans_ex[1:0]);
`else
    assign em_mis = 1'b0;
    assign ex_mis = 1'b0;
`endif

    // Memory op about to be latched (decides whether ACCESS continues).
    assign ex_mem_op = valid_ex & (m2reg_ex | wmem_ex) & ~ex_mis;
    assign in_access = (state_q == ST_ACCESS);

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            em_valid <= 1'b0;
            em_ans   <= '0;
            em_b     <= '0;
            em_rw    <= '0;
            em_wreg  <= 1'b0;
            em_m2reg <= 1'b0;
            em_wmem  <= 1'b0;
            em_size  <= '0;
            em_sext  <= 1'b0;
        end else if (!stall) begin
            em_valid <= valid_ex;
            em_ans   <= ans_ex;
            em_b     <= b_ex;
            em_rw    <= rw_ex;
            em_wreg  <= valid_ex & wreg_ex;
            em_m2reg <= valid_ex & m2reg_ex;
            em_wmem  <= valid_ex & wmem_ex;
            em_size  <= size_ex;
            em_sext  <= sext_ex;
        end
    end

    // FSM
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        timeout = 1'b0;
        stall   = 1'b0;
        if (in_access) begin
            timeout = ~dmem_ack & (cnt_q == CNT_LAST);
            stall   = ~dmem_ack & ~timeout;
        end
        // Completion and idle both latch the next bundle; chain straight
        // into another ACCESS when that bundle is a memory op.
        if (stall || ex_mem_op) state_d = ST_ACCESS;
    end

    // Counter is zero in the first ACCESS cycle of every access.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0)   cnt_q <= '0;
        else if (stall) cnt_q <= cnt_q + 8'd1;
        else            cnt_q <= '0;
    end

    stage_mem_lane u_lane (
        .size    (em_size),
        .addr_lo (em_ans[1:0]),
        .sext    (em_sext),
        .st_data (em_b),
        .rdata   (dmem_rdata),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .ld_data (lane_ld)
    );

    assign stall_mem  = stall;
    assign dmem_req   = in_access;
    assign dmem_we    = in_access & em_wmem;
    assign dmem_addr  = in_access ? {em_ans[31:2], 2'b00} : 32'h0;
    assign dmem_be    = in_access ? lane_be : 4'b0000;
    assign dmem_wdata = in_access ? lane_wdata : 32'h0;

    assign load_done = in_access & dmem_ack & em_m2reg;

    // MEM/WB next value; a stall cycle inserts a bubble instead.
    always_comb begin
        wb_d        = '0;
        wb_d.ans    = em_ans;
        wb_d.rw     = em_rw;
        wb_d.m2reg  = em_m2reg;
        wb_d.wreg   = em_wreg & ~timeout & ~em_mis;
        wb_d.buserr = timeout;
        if (timeout)        wb_d.mdata = BUSERR_DATA;
        else if (load_done) wb_d.mdata = lane_ld;
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0)   wb_q <= '0;
        else if (stall) wb_q <= '0;
        else            wb_q <= wb_d;
    end

`ifdef STAGE_MEM_ALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0)   mis_q <= 1'b0;
        else if (stall) mis_q <= 1'b0;
        else            mis_q <= em_valid & em_mis;
    end
    assign misalign_mem = mis_q;
`endif

    assign ans_mem    = wb_q.ans;
    assign mdata_mem  = wb_q.mdata;
    assign rw_mem     = wb_q.rw;
    assign wreg_mem   = wb_q.wreg;
    assign m2reg_mem  = wb_q.m2reg;
    assign buserr_mem = wb_q.buserr;

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

    localparam int unsigned TO = 255;
    localparam logic [31:0] BERR = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_0;
    logic        valid_ex, wreg_ex, m2reg_ex, wmem_ex, sext_ex;
    logic [31:0] ans_ex, b_ex;
    logic [4:0]  rw_ex;
    logic [1:0]  size_ex;
    logic        stall_mem, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] ans_mem, mdata_mem;
    logic [4:0]  rw_mem;
    logic        wreg_mem, m2reg_mem, buserr_mem;
`ifdef STAGE_MEM_ALIGN_TRAP_EN
    logic        misalign_mem;
`endif

    always #5 clock = ~clock;

    stage_mem #(.TIMEOUT_CYC(TO), .BUSERR_DATA(BERR)) dut (
        .clock(clock), .reset_0(reset_0),
        .valid_ex(valid_ex), .ans_ex(ans_ex), .b_ex(b_ex), .rw_ex(rw_ex),
        .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex), .wmem_ex(wmem_ex),
        .size_ex(size_ex), .sext_ex(sext_ex),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .ans_mem(ans_mem), .mdata_mem(mdata_mem), .rw_mem(rw_mem),
        .wreg_mem(wreg_mem), .m2reg_mem(m2reg_mem),
`ifdef STAGE_MEM_ALIGN_TRAP_EN
        .misalign_mem(misalign_mem),
`endif
        .buserr_mem(buserr_mem)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] ans;
        logic [31:0] b;
        logic [4:0]  rw;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [1:0]  size;
        logic        sext;
    } instr_t;

    // Reference state: instruction sitting in MEM, its ack latency, the
    // cycles it has waited, and the MEM/WB bundle expected after next edge.
    instr_t      cur, nop;
    int          cur_lat, waited;
    logic        ew_wreg, ew_m2reg, ew_buserr;
    logic [31:0] ew_ans, ew_mdata;
    logic [4:0]  ew_rw;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic [7:0]  req_hist;
    int          stall_cnt;
    int          ncmp = 0, nfail = 0;

    function automatic instr_t mk(input logic v, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rw,
                                  input logic wr, input logic ld, input logic st,
                                  input logic [1:0] sz, input logic sx);
        instr_t i;
        i.valid = v; i.ans = a; i.b = b; i.rw = rw; i.wreg = wr;
        i.m2reg = ld; i.wmem = st; i.size = sz; i.sext = sx;
        return i;
    endfunction

    // Sub-word size ignores the low address bits it cannot use.
    function automatic int lane_ofs(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return int'(a);
        if (sz == 2'd1) return (a >= 2'd2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] ld_model(input instr_t i, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * lane_ofs(i.size, i.ans[1:0]));
        if (i.size == 2'd0) begin
            v = v % 32'h100;
            if (i.sext && v >= 32'h80) v = v - 32'h100;
        end else if (i.size == 2'd1) begin
            v = v % 32'h10000;
            if (i.sext && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] be_model(input instr_t i);
        int n;
        n = (i.size == 2'd0) ? 1 : (i.size == 2'd1) ? 2 : 4;
        return 4'(((1 << n) - 1) << lane_ofs(i.size, i.ans[1:0]));
    endfunction

    function automatic logic [31:0] wd_model(input instr_t i);
        if (i.size == 2'd0) return {24'h0, i.b[7:0]} * 32'h0101_0101;
        if (i.size == 2'd1) return {16'h0, i.b[15:0]} * 32'h0001_0001;
        return i.b;
    endfunction

    task automatic model_reset();
        cur = nop; cur_lat = 0; waited = 0;
        ew_wreg = 0; ew_m2reg = 0; ew_buserr = 0;
        ew_ans = 0; ew_mdata = 0; ew_rw = 0;
    endtask

    // One clock cycle: check registered outputs, offer 'in' to the stage,
    // answer the bus, check the combinational outputs, advance the model.
    task automatic step(input instr_t in, input int lat, input logic [31:0] rd);
        logic cur_mem, ack_v, abort, exp_stall;
        @(negedge clock);
        ncmp++;
        if ({wreg_mem, m2reg_mem, buserr_mem} !== {ew_wreg, ew_m2reg, ew_buserr}) begin
            nfail++;
            $display("FAIL wb_ctl: got wreg/m2reg/buserr=%b%b%b want %b%b%b",
                     wreg_mem, m2reg_mem, buserr_mem, ew_wreg, ew_m2reg, ew_buserr);
        end
        if (ew_wreg | ew_m2reg) begin
            ncmp++;
            if ({ans_mem, rw_mem} !== {ew_ans, ew_rw}) begin
                nfail++;
                $display("FAIL wb_ans: got ans=%h rw=%0d want ans=%h rw=%0d",
                         ans_mem, rw_mem, ew_ans, ew_rw);
            end
        end
        if (ew_m2reg) begin
            ncmp++;
            if (mdata_mem !== ew_mdata) begin
                nfail++;
                $display("FAIL wb_mdata: got %h want %h", mdata_mem, ew_mdata);
            end
        end
        valid_ex = in.valid; ans_ex = in.ans; b_ex = in.b; rw_ex = in.rw;
        wreg_ex = in.wreg; m2reg_ex = in.m2reg; wmem_ex = in.wmem;
        size_ex = in.size; sext_ex = in.sext;
        cur_mem = cur.valid & (cur.m2reg | cur.wmem);
        ack_v = cur_mem && (waited >= cur_lat);
        dmem_ack = ack_v;
        dmem_rdata = rd;
        #1;
        abort = cur_mem && !ack_v && (waited == int'(TO) - 1);
        exp_stall = cur_mem && !ack_v && !abort;
        ncmp++;
        if ({dmem_req, stall_mem} !== {cur_mem, exp_stall}) begin
            nfail++;
            $display("FAIL req_stall: got req=%b stall=%b want req=%b stall=%b",
                     dmem_req, stall_mem, cur_mem, exp_stall);
        end
        if (cur_mem) begin
            ncmp++;
            if ({dmem_we, dmem_addr, dmem_be} !== {cur.wmem, cur.ans & 32'hFFFF_FFFC, be_model(cur)}) begin
                nfail++;
                $display("FAIL bus: got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                         dmem_we, dmem_addr, dmem_be, cur.wmem,
                         cur.ans & 32'hFFFF_FFFC, be_model(cur));
            end
            if (cur.wmem) begin
                ncmp++;
                if (dmem_wdata !== wd_model(cur)) begin
                    nfail++;
                    $display("FAIL wdata: got %h want %h", dmem_wdata, wd_model(cur));
                end
            end
        end
        last_we = dmem_we; last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata;
        req_hist = {req_hist[6:0], dmem_req};
        if (stall_mem === 1'b1) stall_cnt++;
        if (exp_stall) begin
            ew_wreg = 0; ew_m2reg = 0; ew_buserr = 0;
            waited++;
        end else begin
            ew_wreg   = cur.valid & cur.wreg & ~abort;
            ew_m2reg  = cur.valid & cur.m2reg;
            ew_buserr = abort;
            ew_ans    = cur.ans;
            ew_rw     = cur.rw;
            ew_mdata  = abort ? BERR : ld_model(cur, rd);
            cur = in; cur_lat = lat; waited = 0;
        end
    endtask

    task automatic check_all_zero(input string name);
        ncmp++;
        if ({stall_mem, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ans_mem,
             mdata_mem, rw_mem, wreg_mem, m2reg_mem, buserr_mem} !== '0) begin
            nfail++;
            $display("FAIL %s: outputs not all zero (req=%b stall=%b ans=%h wreg=%b) want 0",
                     name, dmem_req, stall_mem, ans_mem, wreg_mem);
        end
    endtask

    task automatic test_reset();
        reset_0 = 0;
        valid_ex = 0; ans_ex = 0; b_ex = 0; rw_ex = 0; wreg_ex = 0;
        m2reg_ex = 0; wmem_ex = 0; size_ex = 0; sext_ex = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset_0 = 1;
        model_reset();
    endtask

    task automatic test_alu();
        int s0;
        s0 = stall_cnt;
        step(mk(1, 32'h0000_0010, 32'h0, 5'd5, 1, 0, 0, 2'd2, 0), 0, 32'h0);
        step(nop, 0, 32'h0);
        step(nop, 0, 32'h0);
        ncmp++;
        if ({ans_mem, rw_mem, wreg_mem, stall_cnt} !== {32'h10, 5'd5, 1'b1, s0}) begin
            nfail++;
            $display("FAIL alu_pass: got ans=%h rw=%0d wreg=%b stalls=%0d want 10/5/1/%0d",
                     ans_mem, rw_mem, wreg_mem, stall_cnt, s0);
        end
    endtask

    task automatic test_lb();
        int s0;
        s0 = stall_cnt;
        step(mk(1, 32'h0000_0103, 32'h0, 5'd7, 1, 1, 0, 2'd0, 1), 3, 32'h80FF_FF7F);
        repeat (4) step(nop, 0, 32'h80FF_FF7F);
        ncmp++;
        if ({last_be, stall_cnt - s0} !== {4'b1000, 32'd3}) begin
            nfail++;
            $display("FAIL lb_bus: got be=%b stalls=%0d want 1000/3", last_be, stall_cnt - s0);
        end
        step(nop, 0, 32'h0);
        ncmp++;
        if ({mdata_mem, m2reg_mem} !== {32'hFFFF_FF80, 1'b1}) begin
            nfail++;
            $display("FAIL lb_data: got mdata=%h m2reg=%b want ffffff80/1", mdata_mem, m2reg_mem);
        end
    endtask

    task automatic test_sh();
        step(mk(1, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 0, 0, 1, 2'd1, 0), 0, 32'h0);
        step(nop, 0, 32'h0);
        ncmp++;
        if ({last_we, last_be, last_wdata, last_addr} !== {1'b1, 4'b1100, 32'hABCD_ABCD, 32'h200}) begin
            nfail++;
            $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h want 1/1100/abcdabcd/200",
                     last_we, last_be, last_wdata, last_addr);
        end
        step(nop, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = stall_cnt;
        step(mk(1, 32'h40, 32'h0, 5'd9, 1, 1, 0, 2'd2, 0), 0, 32'h0);
        step(mk(1, 32'h44, 32'hCAFE_F00D, 5'd0, 0, 0, 1, 2'd2, 0), 0, 32'h1357_9BDF);
        step(nop, 0, 32'h0);
        step(nop, 0, 32'h0);
        ncmp++;
        if ({req_hist[2:0], stall_cnt - s0} !== {3'b110, 32'd0}) begin
            nfail++;
            $display("FAIL b2b: got req_hist=%b stalls=%0d want 110/0", req_hist[2:0], stall_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int s0;
        s0 = stall_cnt;
        step(mk(1, 32'h80, 32'h0, 5'd3, 1, 1, 0, 2'd2, 0), 100000, 32'h0);
        repeat (TO) step(nop, 0, $urandom);
        step(nop, 0, 32'h0);
        ncmp++;
        if ({buserr_mem, wreg_mem, stall_cnt - s0} !== {1'b1, 1'b0, 32'(TO - 1)}) begin
            nfail++;
            $display("FAIL timeout: got buserr=%b wreg=%b stalls=%0d want 1/0/%0d",
                     buserr_mem, wreg_mem, stall_cnt - s0, TO - 1);
        end
        step(mk(1, 32'h99, 32'h0, 5'd4, 1, 0, 0, 2'd2, 0), 0, 32'h0);
        step(nop, 0, 32'h0);
        step(nop, 0, 32'h0);
        ncmp++;
        if ({buserr_mem, ans_mem, wreg_mem} !== {1'b0, 32'h99, 1'b1}) begin
            nfail++;
            $display("FAIL resume: got buserr=%b ans=%h wreg=%b want 0/99/1",
                     buserr_mem, ans_mem, wreg_mem);
        end
    endtask

    task automatic test_reset_mid();
        step(mk(1, 32'h120, 32'h0, 5'd6, 1, 1, 0, 2'd2, 0), 100000, 32'h0);
        step(nop, 0, 32'h0);
        step(nop, 0, 32'h0);
        ncmp++;
        if ({dmem_req, stall_mem} !== 2'b11) begin
            nfail++;
            $display("FAIL pre_reset: got req=%b stall=%b want 1/1", dmem_req, stall_mem);
        end
        dmem_ack = 0;
        reset_0 = 0;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        #1 reset_0 = 1;
        step(nop, 0, 32'h0);
        step(mk(1, 32'h55, 32'h0, 5'd8, 1, 0, 0, 2'd2, 0), 0, 32'h0);
        step(nop, 0, 32'h0);
    endtask

    task automatic test_random();
        instr_t in;
        int k;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 2);
            in = mk($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom),
                    1'($urandom_range(0, 1)), k == 1, k == 2, 2'($urandom),
                    1'($urandom_range(0, 1)));
            step(in, $urandom_range(0, 3), $urandom);
        end
        repeat (6) step(nop, 0, 32'h0);
    endtask

    initial begin
        nop = mk(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 2'd0, 0);
        stall_cnt = 0;
        req_hist = '0;
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
